uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit-side control unit for the UART block. It accepts a byte from the host through a valid/ready handshake and holds it in an internal shift register. It sequences the start, data, optional parity and stop bits onto the serial line, timing each bit with its own bit-period and bit-index counters. It is the transmit counterpart of the receiver control unit and sits between the host interface and the serial pin.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period (>=2)
DATA_BITS, 8, data bits per frame (5..8), sent LSB first
PARITY_EN, 0, 1 = append a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
tx_data  in  DATA_BITS  byte to send; sampled only on an accepted handshake
tx_valid  in  1  host has a byte; accepted when tx_valid && tx_ready at a rising edge
tx_abort  in  1  synchronous abort of the frame in flight
tx_ready  out  1  high only in IDLE
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse after the last stop bit completes
serial_out  out  1  registered serial line; idles high

Behaviour:
- Reset values: state=IDLE, serial_out=1, tx_done=0, tx_busy=0, tx_ready=1, counters=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP, DONE. State is encoded as an enum.
- IDLE: serial_out=1.
  - If tx_valid at an edge, tx_data loads into the shift register, the parity accumulator initialises from PARITY_ODD, and the next state is START.
- START: serial_out=0 for exactly CLKS_PER_BIT cycles, then DATA.
  - Handshake latency: the handshake is accepted at edge k; serial_out is 0 from cycle k+1.
- DATA: serial_out = shift_reg[0] for CLKS_PER_BIT cycles per bit. At each bit-period terminal count:
  - the shift register shifts right;
  - the parity accumulator XORs in the sent bit;
  - bit_idx increments.
  - After bit DATA_BITS-1 the next state is PARITY if PARITY_EN, else STOP.
- PARITY: serial_out = accumulated parity for CLKS_PER_BIT cycles, then STOP.
- STOP: serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then DONE.
- DONE: one cycle with tx_done=1 and serial_out=1. The next state is IDLE, where tx_ready is high again.
  - tx_valid during DONE is not accepted.
- Frame length: 1+DATA_BITS+PARITY_EN+STOP_BITS bit periods.
  - tx_done is high in cycle k + CLKS_PER_BIT*(frame bits) + 1.
- Bit-period counter:
  - counts 1..CLKS_PER_BIT and rolls over to 1 at terminal count;
  - clears on every state entry from IDLE;
  - is sized $clog2(CLKS_PER_BIT*2)+1 bits, so it cannot overflow.
- Bit-index counter: 0..DATA_BITS-1, cleared on entry to DATA.
- tx_abort:
  - In START through STOP it forces serial_out=1 on the next edge and sends the state to IDLE.
  - The partial frame is dropped and tx_done is not pulsed.
  - It is ignored in IDLE and DONE.
  - tx_abort together with tx_valid in IDLE: the byte is accepted and abort is ignored.
- tx_data changes after acceptance have no effect on the frame.
- tx_valid held high continuously produces back-to-back frames separated by exactly one DONE cycle plus one IDLE cycle of high line.
- Asynchronous reset mid-frame: serial_out returns high immediately and no tx_done is produced.
- serial_out comes from a flop, not directly from combinational state decode.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP, DONE};
  - default constants UART_CLKS_PER_BIT=10 and UART_DATA_BITS=8, shared with the receiver;
  - function parity_init(odd).
- One sub-module: flex_counter (parameterised width, clear, count_enable, rollover_val, rollover_flag), instantiated twice, for the bit period and the bit index.

Test Plan:
- Reset then idle 20 cycles -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
- Defaults, send 0xA5 accepted at edge 0 -> serial_out levels 0,1,0,1,0,0,1,0,1,1, each held 10 cycles over cycles 1..100. tx_done=1 only in cycle 101; tx_ready=1 in cycle 102.
- PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit 0 in cycles 91..100, stop bit in 101..110, tx_done in cycle 111. Same with PARITY_ODD=1 -> parity bit 1.
- tx_valid held high with 0x3C then 0xC3 -> two complete frames; the line is high for exactly 12 cycles between the last data bit of frame 1 and the start bit of frame 2 (10 stop + DONE + IDLE). The second byte is latched at the IDLE edge.
- tx_abort at cycle 45 (mid-DATA) -> serial_out=1 from cycle 46, state IDLE, no tx_done. The next 0x55 frame is transmitted correctly.
- n_rst low at cycle 30 for 3 cycles -> serial_out=1 asynchronously, tx_ready=1 after release, no tx_done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, default framing constants
// and the parity seed helper used by both directions of the UART.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 10;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } tx_state_t;

  // Seeding the accumulator with 1 turns the running XOR into odd parity.
  function automatic logic parity_init(input logic odd);
    return odd;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear. It counts 1..rollover_val and wraps to 1.
// rollover_flag is high while the count sits at rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_next;

  always_comb begin
    count_next = count_out;
    if (clear)
      count_next = '0;
    else if (count_enable)
      count_next = (count_out == rollover_val) ? NUM_CNT_BITS'(1) : count_out + NUM_CNT_BITS'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_out <= '0;
    else
      count_out <= count_next;
  end

  assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit control: takes a byte over valid/ready and serialises
// start, data (LSB first), optional parity and stop bits on a registered line.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  input  logic                 tx_abort,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT * 2) + 1;
  localparam int IDX_W = $clog2(DATA_BITS) + 1;

  tx_state_t state, state_next;

  logic [CNT_W-1:0]     bit_cnt;
  logic                 bit_tc;
  logic [IDX_W-1:0]     bit_idx;
  logic                 last_bit;
  logic                 stop_half;
  logic                 stop_last;
  logic                 accept;
  logic                 abort_act;
  logic                 cnt_clear;
  logic                 cnt_en;
  logic [DATA_BITS-1:0] shift_reg, shift_d;
  logic                 par_acc, par_d;
  logic                 serial_d;

  assign accept    = (state == IDLE) && tx_valid;
  assign abort_act = tx_abort && (state inside {START, DATA, PARITY, STOP});

  // The period counter steps on the accept edge so every bit period reads 1..CLKS_PER_BIT.
  assign cnt_clear = abort_act || (state == DONE) || ((state == IDLE) && !tx_valid);
  assign cnt_en    = (state != IDLE) || tx_valid;

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_bit_period (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (CNT_W'(CLKS_PER_BIT)),
    .count_out    (bit_cnt),
    .rollover_flag(bit_tc)
  );

  flex_counter #(.NUM_CNT_BITS(IDX_W)) u_bit_index (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state == START),
    .count_enable ((state == DATA) && bit_tc),
    .rollover_val (IDX_W'(DATA_BITS - 1)),
    .count_out    (bit_idx),
    .rollover_flag(last_bit)
  );

  assign stop_last = (STOP_BITS == 1) || stop_half;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (tx_valid) state_next = START;
      START:   if (bit_tc) state_next = DATA;
      DATA:    if (bit_tc && last_bit) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_tc) state_next = STOP;
      STOP:    if (bit_tc && stop_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_act)
      state_next = IDLE;
  end

  always_comb begin
    tx_ready = (state == IDLE);
    tx_busy  = (state != IDLE);
    tx_done  = (state == DONE);
  end

  always_comb begin
    shift_d = shift_reg;
    par_d   = par_acc;
    if (accept) begin
      shift_d = tx_data;
      par_d   = parity_init(PARITY_ODD != 0);
    end else if ((state == DATA) && bit_tc) begin
      shift_d = shift_reg >> 1;
      par_d   = par_acc ^ shift_reg[0];
    end
  end

  // The line flop is loaded from the upcoming state so it switches on the same edge as the FSM.
  always_comb begin
    unique case (state_next)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = par_d;
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg  <= '0;
      par_acc    <= 1'b0;
      serial_out <= 1'b1;
      stop_half  <= 1'b0;
    end else begin
      shift_reg  <= shift_d;
      par_acc    <= par_d;
      serial_out <= serial_d;
      if (state != STOP)
        stop_half <= 1'b0;
      else if (bit_tc)
        stop_half <= ~stop_half;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: default framing plus even/odd parity variants
// driven in parallel, covering back-to-back, abort and mid-frame reset.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_abort;
  logic       rdy0, bsy0, dn0, so0;
  logic       rdy1, bsy1, dn1, so1;
  logic       rdy2, bsy2, dn2, so2;

  int n_pass;
  int n_total;

  uart_tx_ctrl u_def (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_abort(tx_abort),
    .tx_ready(rdy0), .tx_busy(bsy0), .tx_done(dn0), .serial_out(so0)
  );

  uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_abort(tx_abort),
    .tx_ready(rdy1), .tx_busy(bsy1), .tx_done(dn1), .serial_out(so1)
  );

  uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_abort(tx_abort),
    .tx_ready(rdy2), .tx_busy(bsy2), .tx_done(dn2), .serial_out(so2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Expected line level in cycle c after the accepting edge (c=1 is the first start-bit cycle).
  function automatic logic exp_line(input logic [7:0] d, input bit pe, input bit po, input int c);
    int b;
    if (c < 1 || c > (10 + int'(pe)) * 10) return 1'b1;
    b = (c - 1) / 10;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) return po ^ (^d);
    return 1'b1;
  endfunction

  task automatic accept(input logic [7:0] d, input logic ab);
    tx_data  = d;
    tx_valid = 1'b1;
    tx_abort = ab;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_abort = 1'b0;
    tx_data  = ~d;
  endtask

  task automatic wait_all_idle();
    int n;
    n = 0;
    while (!(rdy0 && rdy1 && rdy2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {rdy0, rdy1, rdy2}, 3'b111);
    @(negedge clk);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    n_rst    = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_abort = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("rst_line c%0d", c), so0, 1'b1);
      check($sformatf("rst_ready c%0d", c), rdy0, 1'b1);
      check($sformatf("rst_busy c%0d", c), bsy0, 1'b0);
      check($sformatf("rst_done c%0d", c), {dn0, dn1, dn2}, 3'b000);
    end

    // 0xA5 on all three framings at once
    accept(8'hA5, 1'b0);
    for (int c = 1; c <= 112; c++) begin
      @(negedge clk);
      check($sformatf("a5_def_line c%0d", c), so0, exp_line(8'hA5, 0, 0, c));
      check($sformatf("a5_even_line c%0d", c), so1, exp_line(8'hA5, 1, 0, c));
      check($sformatf("a5_odd_line c%0d", c), so2, exp_line(8'hA5, 1, 1, c));
      check($sformatf("a5_def_done c%0d", c), dn0, c == 101);
      check($sformatf("a5_par_done c%0d", c), {dn1, dn2}, (c == 111) ? 2'b11 : 2'b00);
      check($sformatf("a5_def_ready c%0d", c), rdy0, c >= 102);
      check($sformatf("a5_def_busy c%0d", c), bsy0, c < 102);
      check($sformatf("a5_par_ready c%0d", c), rdy1, c >= 112);
    end

    // back-to-back frames with tx_valid held high
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 206; c++) begin
      @(negedge clk);
      if (c <= 102)
        check($sformatf("b2b_f1_line c%0d", c), so0, exp_line(8'h3C, 0, 0, c));
      else
        check($sformatf("b2b_f2_line c%0d", c), so0, exp_line(8'hC3, 0, 0, c - 102));
      check($sformatf("b2b_done c%0d", c), dn0, (c == 101) || (c == 203));
      check($sformatf("b2b_ready c%0d", c), rdy0, (c == 102) || (c >= 204));
      if (c == 1) tx_data = 8'hC3;
      if (c == 150) tx_valid = 1'b0;
    end
    wait_all_idle();

    // abort in the middle of the data bits
    accept(8'h96, 1'b0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      check($sformatf("abort_line c%0d", c), so0, (c <= 45) ? exp_line(8'h96, 0, 0, c) : 1'b1);
      check($sformatf("abort_done c%0d", c), {dn0, dn1, dn2}, 3'b000);
      check($sformatf("abort_ready c%0d", c), rdy0, c >= 46);
      if (c == 45) tx_abort = 1'b1;
      if (c == 46) tx_abort = 1'b0;
    end

    // abort raised together with valid in IDLE is ignored
    accept(8'h55, 1'b1);
    for (int c = 1; c <= 102; c++) begin
      @(negedge clk);
      check($sformatf("x55_line c%0d", c), so0, exp_line(8'h55, 0, 0, c));
      check($sformatf("x55_done c%0d", c), dn0, c == 101);
      check($sformatf("x55_ready c%0d", c), rdy0, c >= 102);
    end
    wait_all_idle();

    // asynchronous reset while the line is low
    accept(8'h00, 1'b0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      check($sformatf("rstmid_line c%0d", c), so0, exp_line(8'h00, 0, 0, c));
    end
    n_rst = 1'b0;
    #1;
    check("rstmid_async_line", {so0, so1, so2}, 3'b111);
    check("rstmid_async_ready", rdy0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rstmid_hold_ready c%0d", c), rdy0, 1'b1);
      check($sformatf("rstmid_hold_busy c%0d", c), bsy0, 1'b0);
      check($sformatf("rstmid_hold_done c%0d", c), dn0, 1'b0);
    end
    n_rst = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_line c%0d", c), so0, 1'b1);
      check($sformatf("post_rst_done c%0d", c), {dn0, dn1, dn2}, 3'b000);
      check($sformatf("post_rst_ready c%0d", c), rdy0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
